// File: rtl/tff_arb_pkg.sv
// Shared definitions for the toggle-register arbiter: FSM encoding,
// completion counter width and default sizing.
package tff_arb_pkg;

    // Transaction phases, in the order a transaction walks through them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    // Width of the completed-transaction counter (wraps 255 -> 0).
    localparam int DONE_CNT_W = 8;

    // Default sizing of the block.
    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/tff_arbiter_rr_pick.sv
// rr_pick: combinational winner selection for the toggle-register arbiter.
// Searches from pointer+1 upward, wrapping modulo NREQ. With fixed_prio set
// the search always starts at index 0, so the lowest requesting index wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] pointer,
    input  logic            fixed_prio,
    output logic [NREQ-1:0] winner_oh,
    output logic [IDXW-1:0] winner_idx,
    output logic            valid
);

    int              start;
    int              cand;
    logic [NREQ-1:0] cand_oh;

    // Walk the NREQ candidates in priority order and keep the first requester.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = 0;
        cand_oh    = '0;
        // A start of NREQ-1 makes the first candidate index 0.
        start      = fixed_prio ? (NREQ - 1) : int'(pointer);
        for (int k = 1; k <= NREQ; k++) begin
            cand    = (start + k) % NREQ;
            cand_oh = {{(NREQ-1){1'b0}}, 1'b1} << cand;
            if (!valid && ((req & cand_oh) != '0)) begin
                winner_oh  = cand_oh;
                winner_idx = IDXW'(cand);
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tff_arbiter.sv
// tff_arbiter: shares one WIDTH-bit toggle register between NREQ requesters.
// A granted requester's mask is captured at grant, XORed into q one cycle
// later, and an ack pulse plus a done_cnt increment follow one cycle after.
// Optional build macro: TFF_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// requesting index wins) instead of the default round-robin.
//
// Handshake: a requester holds req high with a stable mask until it is
// granted; the mask is captured on the grant edge, so req and mask may change
// afterwards without affecting the transaction. ack is a single-cycle pulse
// to the winner, visible in the cycle right after the ACK state. A req still
// high in the IDLE cycle after ack is treated as a brand-new request.
module tff_arbiter
    import tff_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mask,
    input  logic                  clr,
    output logic [WIDTH-1:0]      q,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [DONE_CNT_W-1:0] done_cnt,
    output logic [1:0]            state_dbg
);

    localparam int IDXW = $clog2(NREQ);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      q_q, q_d;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic [DONE_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0]       ptr_q, ptr_d;
    logic [IDXW-1:0]       widx_q, widx_d;

    logic [NREQ-1:0]       pick_oh;
    logic [IDXW-1:0]       pick_idx;
    logic                  pick_valid;
    logic [WIDTH-1:0]      pick_mask;
    logic                  fixed_prio;

`ifdef TFF_ARB_FIXED_PRIO_EN
    assign fixed_prio = 1'b1;
`else
    assign fixed_prio = 1'b0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req        (req),
        .pointer    (ptr_q),
        .fixed_prio (fixed_prio),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE waits for any request, then APPLY and ACK take one cycle each.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_APPLY;
            ST_APPLY: state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Slice out the mask belonging to the current winner.
    always_comb begin
        pick_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) pick_mask = mask[i*WIDTH +: WIDTH];
        end
    end

    // Outputs and datapath: grant/capture in IDLE, toggle in APPLY, complete in ACK.
    always_comb begin
        gnt_d  = gnt_q;
        mask_d = mask_q;
        widx_d = widx_q;
        ptr_d  = ptr_q;
        ack_d  = '0;
        cnt_d  = cnt_q;
        q_d    = q_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d  = pick_oh;
                    mask_d = pick_mask;
                    widx_d = pick_idx;
                end
            end
            ST_APPLY: begin
                q_d = q_q ^ mask_q;
            end
            ST_ACK: begin
                ack_d = gnt_q;
                cnt_d = cnt_q + DONE_CNT_W'(1);
                ptr_d = widx_q;
                gnt_d = '0;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
        // Clear has priority over a toggle landing in the same cycle.
        if (clr) q_d = '0;
        busy_d = (state_d != ST_IDLE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q    <= '0;
            mask_q <= '0;
            gnt_q  <= '0;
            ack_q  <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            ptr_q  <= IDXW'(NREQ - 1);
            widx_q <= '0;
        end else begin
            q_q    <= q_d;
            mask_q <= mask_d;
            gnt_q  <= gnt_d;
            ack_q  <= ack_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            widx_q <= widx_d;
        end
    end

    assign q         = q_q;
    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign done_cnt  = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tff_arbiter.sv
// Self-checking bench for tff_arbiter: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_tff_arbiter;
    import tff_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int MW    = NREQ * WIDTH;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [MW-1:0]         mask;
    logic                  clr;
    logic [WIDTH-1:0]      q;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [DONE_CNT_W-1:0] done_cnt;
    logic [1:0]            state_dbg;

    tff_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mask      (mask),
        .clr       (clr),
        .q         (q),
        .gnt       (gnt),
        .ack       (ack),
        .busy      (busy),
        .done_cnt  (done_cnt),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, tracked by its age in cycles
    // since the grant (0 = no transaction open).
    int m_q, m_cnt, m_ptr, m_age, m_win, m_mask, m_ack;

    function automatic int model_pick(input int r, input int ptr);
`ifdef TFF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (((r >> i) & 1) != 0) return i;
`else
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (ptr + k) % NREQ;
            if (((r >> c) & 1) != 0) return c;
        end
`endif
        return 0;
    endfunction

    task automatic model_edge();
        m_ack = 0;
        if (!reset) begin
            m_q = 0; m_cnt = 0; m_ptr = NREQ - 1; m_age = 0; m_win = 0; m_mask = 0;
        end else begin
            if (m_age == 0) begin
                if (req != '0) begin
                    m_win  = model_pick(int'(req), m_ptr);
                    m_mask = (int'(mask) >> (m_win * WIDTH)) & ((1 << WIDTH) - 1);
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                m_q   = m_q ^ m_mask;
                m_age = 2;
            end else begin
                m_ack = 1 << m_win;
                m_cnt = (m_cnt + 1) % 256;
                m_ptr = m_win;
                m_age = 0;
            end
            if (clr) m_q = 0;
        end
    endtask

    // Driver: apply one cycle of inputs, advance the model, check all outputs.
    task automatic cycle(input logic rs, input logic [NREQ-1:0] r,
                         input logic [MW-1:0] mk, input logic c);
        int exp_state;
        reset = rs; req = r; mask = mk; clr = c;
        model_edge();
        @(posedge clk);
        #1;
        exp_state = (m_age == 0) ? int'(ST_IDLE) : (m_age == 1) ? int'(ST_APPLY) : int'(ST_ACK);
        check_eq("q",        32'(q),        32'(m_q));
        check_eq("gnt",      32'(gnt),      (m_age != 0) ? 32'(1 << m_win) : 32'd0);
        check_eq("ack",      32'(ack),      32'(m_ack));
        check_eq("busy",     32'(busy),     (m_age != 0) ? 32'd1 : 32'd0);
        check_eq("done_cnt", 32'(done_cnt), 32'(m_cnt));
        check_eq("state",    32'(state_dbg), 32'(exp_state));
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
    endtask

    logic [31:0] rnd;
    logic [NREQ-1:0] r_req;

    initial begin
        reset = 1'b0; req = '0; mask = '0; clr = 1'b0;

        // Reset for two cycles, then release with no requests.
        do_reset();
        cycle(1'b1, '0, '0, 1'b0);
        check_eq("rst_q",    32'(q), 32'd0);
        check_eq("rst_gnt",  32'(gnt), 32'd0);
        check_eq("rst_ack",  32'(ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cnt",  32'(done_cnt), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // Single transaction: requester 0, mask 1010; req dropped after grant.
        cycle(1'b1, 4'b0001, 16'h000A, 1'b0);
        check_eq("t1_gnt", 32'(gnt), 32'h1);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b0);
        check_eq("t1_q", 32'(q), 32'hA);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b0);
        check_eq("t1_ack", 32'(ack), 32'h1);
        check_eq("t1_cnt", 32'(done_cnt), 32'd1);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b0);
        check_eq("t1_ack_off", 32'(ack), 32'h0);

        // All four requesting, every mask 0001: grant order from reset.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 4'b1111, 16'h1111, 1'b0);
            if (k % 3 == 0) begin
`ifdef TFF_ARB_FIXED_PRIO_EN
                check_eq("rr_order", 32'(gnt), 32'h1);
`else
                check_eq("rr_order", 32'(gnt), 32'(1 << (k / 3)));
`endif
            end
        end

        // Clear in the APPLY cycle wins over the toggle; still acks and counts.
        do_reset();
        cycle(1'b1, 4'b0001, 16'h0005, 1'b0);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b0);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b0);
        check_eq("clr_pre_q", 32'(q), 32'h5);
        cycle(1'b1, 4'b0001, 16'h000F, 1'b0);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1);
        check_eq("clr_q", 32'(q), 32'h0);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b0);
        check_eq("clr_ack", 32'(ack), 32'h1);
        check_eq("clr_cnt", 32'(done_cnt), 32'd2);

        // Reset during APPLY aborts the transaction.
        cycle(1'b1, 4'b0010, 16'h0030, 1'b0);
        cycle(1'b0, 4'b0000, 16'h0000, 1'b0);
        check_eq("abort_q",   32'(q), 32'h0);
        check_eq("abort_ack", 32'(ack), 32'h0);
        check_eq("abort_cnt", 32'(done_cnt), 32'd0);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b0);
        check_eq("abort_ack2", 32'(ack), 32'h0);
        check_eq("abort_cnt2", 32'(done_cnt), 32'd0);

        // 256 single transactions wrap done_cnt back to 0.
        do_reset();
        for (int t = 0; t < 256; t++) begin
            rnd = $urandom;
            r_req = 4'b0001 << rnd[1:0];
            cycle(1'b1, r_req, rnd[31:16], 1'b0);
            cycle(1'b1, '0, '0, 1'b0);
            cycle(1'b1, '0, '0, 1'b0);
            if (t == 254) check_eq("wrap_255", 32'(done_cnt), 32'd255);
        end
        check_eq("wrap_0", 32'(done_cnt), 32'd0);

        // Randomized traffic with occasional clear and reset.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rnd = $urandom;
            r_req = (rnd[7:5] == 3'd0) ? '0 : rnd[NREQ-1:0];
            cycle((rnd[15:8] != 8'd0), r_req, rnd[31:16], (rnd[4:1] == 4'd0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
